// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID pipeline register with redirect > flush > stall > halted > normal priority.
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   parameter int unsigned N_INSTR   = 512
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   output logic [31:0] ifid_inst,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);

   typedef enum logic [2:0] {
      CASE_REDIRECT,
      CASE_FLUSH,
      CASE_STALL,
      CASE_HALTED,
      CASE_HALT,
      CASE_FETCH
   } fetch_case_e;

   logic [31:0] pc_q,          pc_d;
   logic [31:0] ifid_inst_q,   ifid_inst_d;
   logic [31:0] ifid_pc4_q,    ifid_pc4_d;
   logic        ifid_valid_q,  ifid_valid_d;
   logic        halted_q,      halted_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   fetch_case_e fetch_case;
   logic        halt_cond;
   logic [31:0] pc_plus4;

   assign pc_plus4  = pc_q + 32'd4;
   // End of memory is judged on the word index so N_INSTR stays in words.
   assign halt_cond = (imem_inst == HALT_WORD) || ({2'b00, pc_q[31:2]} >= 32'(N_INSTR));

   always_comb begin
      if (redirect)          fetch_case = CASE_REDIRECT;
      else if (flush)        fetch_case = CASE_FLUSH;
      else if (stall)        fetch_case = CASE_STALL;
      else if (halted_q)     fetch_case = CASE_HALTED;
      else if (halt_cond)    fetch_case = CASE_HALT;
      else                   fetch_case = CASE_FETCH;
   end

   always_comb begin
      // NOTE: every next-state signal defaults to its register so no path infers a latch.
      pc_d          = pc_q;
      ifid_inst_d   = ifid_inst_q;
      ifid_pc4_d    = ifid_pc4_q;
      ifid_valid_d  = ifid_valid_q;
      halted_d      = halted_q;
      fetch_count_d = fetch_count_q;

      case (fetch_case)
         CASE_REDIRECT: begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            ifid_inst_d  = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_valid_d = 1'b0;
            halted_d     = 1'b0;
         end
         CASE_FLUSH, CASE_HALTED: begin
            ifid_inst_d  = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_valid_d = 1'b0;
         end
         CASE_STALL: ;
         CASE_HALT: begin
            ifid_inst_d  = 32'h0;
            ifid_pc4_d   = 32'h0;
            ifid_valid_d = 1'b0;
            halted_d     = 1'b1;
         end
         CASE_FETCH: begin
            ifid_inst_d   = imem_inst;
            ifid_pc4_d    = pc_plus4;
            ifid_valid_d  = 1'b1;
            pc_d          = pc_plus4;
            fetch_count_d = fetch_count_q + 32'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q          <= RESET_PC;
         ifid_inst_q   <= 32'h0;
         ifid_pc4_q    <= 32'h0;
         ifid_valid_q  <= 1'b0;
         halted_q      <= 1'b0;
         fetch_count_q <= 32'h0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         pc_q          <= pc_d;
         ifid_inst_q   <= ifid_inst_d;
         ifid_pc4_q    <= ifid_pc4_d;
         ifid_valid_q  <= ifid_valid_d;
         halted_q      <= halted_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign ifid_inst   = ifid_inst_q;
   assign ifid_pc4    = ifid_pc4_q;
   assign ifid_valid  = ifid_valid_q;
   assign halted      = halted_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: a default-depth instance driven through directed
// scenarios with a delivery scoreboard, plus an N_INSTR=4 instance for end-of-memory halt.
module tb_instr_fetch_stage;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst_a, stall_a, flush_a, redirect_a;
   logic [31:0] redirect_pc_a, imem_addr_a, imem_inst_a;
   logic [31:0] ifid_inst_a, ifid_pc4_a, fetch_count_a;
   logic        ifid_valid_a, halted_a;
   logic [31:0] mem_a [0:511];

   logic        rst_b;
   logic        stall_b = 1'b0, flush_b = 1'b0, redirect_b = 1'b0;
   logic [31:0] redirect_pc_b = 32'h0;
   logic [31:0] imem_addr_b, imem_inst_b, ifid_inst_b, ifid_pc4_b, fetch_count_b;
   logic        ifid_valid_b, halted_b;
   logic [31:0] mem_b [0:7];

   assign imem_inst_a = (imem_addr_a < 32'h800) ? mem_a[imem_addr_a[10:2]] : 32'h0;
   assign imem_inst_b = (imem_addr_b < 32'h20)  ? mem_b[imem_addr_b[4:2]]  : 32'h0;

   instr_fetch_stage u_dut_a (
      .CLK(CLK), .RST(rst_a), .stall(stall_a), .flush(flush_a),
      .redirect(redirect_a), .redirect_pc(redirect_pc_a),
      .imem_addr(imem_addr_a), .imem_inst(imem_inst_a),
      .ifid_inst(ifid_inst_a), .ifid_pc4(ifid_pc4_a), .ifid_valid(ifid_valid_a),
      .halted(halted_a), .fetch_count(fetch_count_a)
   );

   instr_fetch_stage #(.N_INSTR(4)) u_dut_b (
      .CLK(CLK), .RST(rst_b), .stall(stall_b), .flush(flush_b),
      .redirect(redirect_b), .redirect_pc(redirect_pc_b),
      .imem_addr(imem_addr_b), .imem_inst(imem_inst_b),
      .ifid_inst(ifid_inst_b), .ifid_pc4(ifid_pc4_b), .ifid_valid(ifid_valid_b),
      .halted(halted_b), .fetch_count(fetch_count_b)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc4;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_cnt  = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_a();
      stall_a = 1'b0; flush_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = 32'h0;
   endtask

   // Pop one expected delivery whenever IF/ID reports a real instruction.
   task automatic drain();
      exp_t e;
      if (ifid_valid_a) begin
         if (sb.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            check("sb_inst", ifid_inst_a, e.inst);
            check("sb_pc4",  ifid_pc4_a,  e.pc4);
         end
      end
   endtask

   task automatic fetch_a(input logic [31:0] pc);
      sb.push_back('{inst: mem_a[pc[10:2]], pc4: pc + 32'd4});
      exp_cnt = exp_cnt + 32'd1;
      tick();
      drain();
      check("fetch_valid", {31'h0, ifid_valid_a}, 32'd1);
      check("fetch_count", fetch_count_a, exp_cnt);
      check("fetch_addr",  imem_addr_a, pc + 32'd4);
   endtask

   task automatic bubble_a(input string tag, input logic [31:0] addr);
      check({tag, "_valid"}, {31'h0, ifid_valid_a}, 32'd0);
      check({tag, "_inst"},  ifid_inst_a, 32'h0);
      check({tag, "_pc4"},   ifid_pc4_a,  32'h0);
      check({tag, "_addr"},  imem_addr_a, addr);
      check({tag, "_count"}, fetch_count_a, exp_cnt);
   endtask

   task automatic redirect_to(input logic [31:0] target);
      redirect_a = 1'b1; redirect_pc_a = target;
      tick();
      clear_a();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 512; i++) mem_a[i] = 32'h1000_0000 | 32'(i);
      mem_a[0] = 32'h2008_0001;
      mem_a[1] = 32'h2009_0002;
      mem_a[3] = HALT;
      for (int i = 0; i < 8; i++) mem_b[i] = 32'h0000_0013 + 32'(i << 8);

      clear_a();
      rst_a = 1'b1;
      rst_b = 1'b1;
      #3;
      bubble_a("reset", 32'h0);
      check("reset_halted", {31'h0, halted_a}, 32'd0);
      #9 rst_a = 1'b0;

      // Free run over the first two words.
      fetch_a(32'h0);
      fetch_a(32'h4);

      // Stall holds PC, IF/ID and the count.
      stall_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_addr",  imem_addr_a, 32'h8);
         check("stall_inst",  ifid_inst_a, 32'h2009_0002);
         check("stall_pc4",   ifid_pc4_a,  32'h8);
         check("stall_count", fetch_count_a, 32'd2);
      end
      stall_a = 1'b0;
      fetch_a(32'h8);

      // Halt word at 0x0C is never delivered.
      tick();
      check("halt_halted", {31'h0, halted_a}, 32'd1);
      bubble_a("halt", 32'hC);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("halted_hold", {31'h0, halted_a}, 32'd1);
         bubble_a("halted", 32'hC);
      end

      // Redirect leaves the halted state.
      redirect_to(32'h4);
      check("unhalt", {31'h0, halted_a}, 32'd0);
      bubble_a("redir4", 32'h4);
      fetch_a(32'h4);

      // Redirect outranks flush and stall; target is word aligned.
      redirect_to(32'h10);
      bubble_a("redir10", 32'h10);
      stall_a = 1'b1; flush_a = 1'b1; redirect_a = 1'b1; redirect_pc_a = 32'h42;
      tick();
      clear_a();
      bubble_a("redir_prio", 32'h40);
      fetch_a(32'h40);

      // Flush alone refetches the discarded word.
      flush_a = 1'b1;
      tick();
      clear_a();
      bubble_a("flush", 32'h44);
      fetch_a(32'h44);

      // Redirect while the halt word is presented wins.
      redirect_to(32'hC);
      check("halt_word_seen", imem_inst_a, HALT);
      redirect_to(32'h20);
      check("halt_vs_redirect", {31'h0, halted_a}, 32'd0);
      bubble_a("halt_vs_redirect", 32'h20);

      // Last memory word fetches, the next index halts.
      redirect_to(32'h7FC);
      fetch_a(32'h7FC);
      tick();
      check("eom_halted", {31'h0, halted_a}, 32'd1);
      bubble_a("eom", 32'h800);

      // Asynchronous reset between edges with PC at 0x20.
      redirect_to(32'h1C);
      fetch_a(32'h1C);
      #2 rst_a = 1'b1;
      exp_cnt = 32'h0;
      #1;
      bubble_a("async_rst", 32'h0);
      check("async_rst_halted", {31'h0, halted_a}, 32'd0);
      redirect_a = 1'b1; redirect_pc_a = 32'h100; stall_a = 1'b1;
      tick();
      bubble_a("rst_held", 32'h0);
      #2 rst_a = 1'b0;
      clear_a();
      fetch_a(32'h0);

      // Four-word memory halts at the end of memory.
      rst_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("b_inst",  ifid_inst_b, mem_b[i]);
         check("b_pc4",   ifid_pc4_b,  32'((i + 1) * 4));
         check("b_valid", {31'h0, ifid_valid_b}, 32'd1);
      end
      tick();
      check("b_halted", {31'h0, halted_b}, 32'd1);
      check("b_addr",   imem_addr_b, 32'h10);
      check("b_count",  fetch_count_b, 32'd4);
      check("b_valid_end", {31'h0, ifid_valid_b}, 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the PC loaded on reset.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, the instruction encoding that ends fetch.
REQ-003 SHALL have parameter N_INSTR, default 512, the instruction memory depth in words.
REQ-004 CLK  in  1  clock; all state updates on posedge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 stall  in  1  hold PC and IF/ID register.
REQ-007 flush  in  1  replace IF/ID contents with a bubble.
REQ-008 redirect  in  1  branch/jump taken; load redirect_pc.
REQ-009 redirect_pc  in  32  target address.
REQ-010 imem_addr  out  32  fetch address to instruction memory.
REQ-011 imem_inst  in  32  instruction word returned combinationally for imem_addr.
REQ-012 ifid_inst  out  32  IF/ID instruction.
REQ-013 ifid_pc4  out  32  IF/ID PC+4 of that instruction.
REQ-014 ifid_valid  out  1  IF/ID holds a real instruction.
REQ-015 halted  out  1  fetch has stopped on halt word or end of memory.
REQ-016 fetch_count  out  32  number of instructions delivered into IF/ID.

Function
REQ-017 imem_addr SHALL equal the internal PC combinationally, with no added latency.
REQ-018 Each posedge SHALL apply exactly one case, in this priority: redirect > flush > stall > halted > normal.
REQ-019 redirect: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble; halted <= 0; this case applies regardless of stall, flush or halted.
REQ-020 flush without redirect: IF/ID <= bubble; PC holds, so the discarded word is refetched; halted unchanged.
REQ-021 stall, with no redirect or flush: PC, IF/ID, halted and fetch_count all hold.
REQ-022 halted, with no redirect, flush or stall: PC holds; IF/ID <= bubble.
REQ-023 normal with a valid word: ifid_inst <= imem_inst; ifid_pc4 <= PC+4; ifid_valid <= 1; PC <= PC+4; fetch_count += 1.
REQ-024 Halt condition SHALL be imem_inst == HALT_WORD or PC[31:2] >= N_INSTR, evaluated only in the normal case.
REQ-025 normal with halt condition: IF/ID <= bubble; halted <= 1; PC holds; fetch_count holds; the halt word is never delivered.
REQ-026 A bubble SHALL be ifid_inst = 0 (NOP), ifid_pc4 = 0, ifid_valid = 0.
REQ-027 PC+4 SHALL wrap modulo 2^32; fetch_count SHALL wrap modulo 2^32.
REQ-028 A redirect in the same cycle a halt word is presented SHALL take precedence; halted stays 0.
REQ-029 Outputs SHALL be driven only from registers, except imem_addr (REQ-017).

Reset
REQ-030 RST high SHALL immediately set PC = RESET_PC, the IF/ID register to a bubble, halted = 0 and fetch_count = 0, independent of CLK.
REQ-031 RST asserted mid-operation SHALL discard pending redirect, stall and halt state; fetch SHALL resume from RESET_PC on the first posedge after deassertion.
REQ-032 While RST is high, posedges SHALL cause no state change.

Verification
REQ-033 Reset then free run, with imem words 0x20080001, 0x20090002 at addresses 0 and 4 -> imem_addr 0, 4, 8; after posedge 1: ifid_inst=0x20080001, ifid_pc4=4, valid=1; after posedge 2: ifid_inst=0x20090002, ifid_pc4=8; fetch_count=2.
REQ-034 At PC=8, stall high for 3 cycles -> imem_addr stays 8; IF/ID and fetch_count frozen; advance resumes on the first cycle after stall drops.
REQ-035 At PC=0x10, stall=1, flush=1 and redirect=1 with redirect_pc=0x42 -> next PC=0x40; ifid_valid=0; ifid_inst=0.
REQ-036 Word at 0x0C is 0xFFFFFFFF -> halted=1 after that posedge; PC stays 0x0C; ifid_valid=0 on all later cycles; fetch_count=3. Then redirect to 0x04 -> halted=0 and fetch resumes at 0x04.
REQ-037 With N_INSTR=4 and no halt word -> halted rises when PC=0x10; fetch_count=4.
REQ-038 RST pulsed between clock edges while PC=0x20 -> PC=0 and outputs return to reset values immediately, before the next posedge.
